// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
//   Shared definitions for the multi-cycle MIPS-subset controller:
//   FSM state encoding, opcode/funct constants, ALU / extender / mux select
//   codes and the bundled control-word struct passed from the decoder to the
//   top level.
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        WB_R     = 4'd3,
        EXEC_I   = 4'd4,
        WB_I     = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        WB_MEM   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_LUI  = 3'b111;

    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwr;
        logic       pcwrcond;
        logic       iord;
        logic       memr;
        logic       memw;
        logic       irwr;
        logic       mem2r;
        logic       regdst;
        logic       regw;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] extop;
        logic [2:0] aluctrl;
    } ctrl_t;

    function automatic logic is_legal_rtype(input logic [5:0] fn);
        return (fn == FN_ADDU) || (fn == FN_SUBU);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
//   Purely combinational control-word decode for the multi-cycle controller.
//   Ports:
//     state     in  current FSM state
//     OpCode    in  IR[31:26]
//     funct     in  IR[5:0]
//     mem_ready in  memory handshake (qualifies the FETCH PC/IR writes)
//     ctrl      out bundled strobes and mux/ALU/extender selects
// ---------------------------------------------------------------------------
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] OpCode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.memr    = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluctrl = ALU_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
                // PC+4 and IR are only committed on the cycle memory delivers
                ctrl.pcwr    = mem_ready;
                ctrl.irwr    = mem_ready;
            end
            DECODE: begin
                // speculative branch target into ALUOut
                ctrl.alusrcb = SRCB_BRANCH;
                ctrl.aluctrl = ALU_ADD;
                ctrl.extop   = EXT_SIGN;
            end
            EXEC_R: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_RT;
                ctrl.aluctrl = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
            end
            WB_R: begin
                ctrl.regdst = 1'b1;
                ctrl.regw   = 1'b1;
            end
            EXEC_I, WB_I: begin
                // extender and ALU op stay valid through write-back
                if (OpCode == OP_LUI) begin
                    ctrl.extop   = EXT_UPPER;
                    ctrl.aluctrl = ALU_LUI;
                end else begin
                    ctrl.extop   = EXT_ZERO;
                    ctrl.aluctrl = ALU_OR;
                end
                if (state == EXEC_I) begin
                    ctrl.alusrca = 1'b1;
                    ctrl.alusrcb = SRCB_IMM;
                end else begin
                    ctrl.regw    = 1'b1;
                end
            end
            MEM_ADDR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.extop   = EXT_SIGN;
                ctrl.aluctrl = ALU_ADD;
            end
            MEM_RD: begin
                ctrl.memr = 1'b1;
                ctrl.iord = 1'b1;
            end
            WB_MEM: begin
                ctrl.regw  = 1'b1;
                ctrl.mem2r = 1'b1;
            end
            MEM_WR: begin
                ctrl.memw = 1'b1;
                ctrl.iord = 1'b1;
            end
            BRANCH: begin
                ctrl.alusrca  = 1'b1;
                ctrl.alusrcb  = SRCB_RT;
                ctrl.aluctrl  = ALU_SUB;
                ctrl.pcwrcond = 1'b1;
                ctrl.pcsrc    = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl.pcwr  = 1'b1;
                ctrl.pcsrc = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle controller FSM for the MIPS-subset datapath. Sequences
//   FETCH/DECODE/EXEC/MEM/WB, waits on the memory ready handshake, traps on
//   illegal opcodes and counts retired instructions.
//   Ports:
//     clk, rst_n            clock / async active-low reset
//     OpCode, funct         instruction fields from IR
//     zero                  ALU zero flag (consumed by the datapath PC gate)
//     mem_ready             current MemR/MemW access completes this cycle
//     PCWr..Aluctrl         datapath strobes and selects
//     illegal               sticky illegal-opcode flag
//     retired               completed-instruction count (wraps)
//     state                 current FSM state (debug)
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWr,
    output logic             PCWrCond,
    output logic             IorD,
    output logic             MemR,
    output logic             MemW,
    output logic             IRWr,
    output logic             Mem2R,
    output logic             RegDst,
    output logic             RegW,
    output logic             AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic [1:0]       PCSrc,
    output logic [1:0]       ExtOp,
    output logic [2:0]       Aluctrl,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    state_t           state_q, state_d;
    ctrl_t            dec_ctrl, out_ctrl;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    // The branch decision is made in the datapath from PCWrCond & zero.
    logic unused_zero;
    assign unused_zero = zero;

    ctrl_decode u_decode (
        .state     (state_q),
        .OpCode    (OpCode),
        .funct     (funct),
        .mem_ready (mem_ready),
        .ctrl      (dec_ctrl)
    );

    // Squash outputs while reset is held so a memory access aborts at once.
    always_comb begin
        out_ctrl = dec_ctrl;
        if (!rst_n) begin
            out_ctrl = '0;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (OpCode)
                    OP_RTYPE:      state_d = is_legal_rtype(funct) ? EXEC_R : TRAP;
                    OP_ORI, OP_LUI: state_d = EXEC_I;
                    OP_LW, OP_SW:  state_d = MEM_ADDR;
                    OP_BEQ:        state_d = BRANCH;
                    OP_J:          state_d = JUMP;
                    default:       state_d = TRAP;
                endcase
            end
            EXEC_R:   state_d = WB_R;
            EXEC_I:   state_d = WB_I;
            MEM_ADDR: state_d = (OpCode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   state_d = mem_ready ? WB_MEM : MEM_RD;
            MEM_WR:   state_d = mem_ready ? FETCH : MEM_WR;
            TRAP:     state_d = TRAP;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        case (state_q)
            WB_R, WB_I, WB_MEM, BRANCH, JUMP: retire = 1'b1;
            MEM_WR:                           retire = mem_ready;
            default:                          retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == TRAP);
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign PCWr     = out_ctrl.pcwr;
    assign PCWrCond = out_ctrl.pcwrcond;
    assign IorD     = out_ctrl.iord;
    assign MemR     = out_ctrl.memr;
    assign MemW     = out_ctrl.memw;
    assign IRWr     = out_ctrl.irwr;
    assign Mem2R    = out_ctrl.mem2r;
    assign RegDst   = out_ctrl.regdst;
    assign RegW     = out_ctrl.regw;
    assign AluSrcA  = out_ctrl.alusrca;
    assign AluSrcB  = out_ctrl.alusrcb;
    assign PCSrc    = out_ctrl.pcsrc;
    assign ExtOp    = out_ctrl.extop;
    assign Aluctrl  = out_ctrl.aluctrl;
    assign illegal  = illegal_q;
    assign retired  = retired_q;
    assign state    = state_q;

endmodule
